// File: rtl/add16_seq_pkg.sv
// Shared constants for the nibble-serial adder/subtractor.
// FSM state encoding and op encoding live here so bench and RTL agree.
package add16_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add16_seq_if.sv
// Request/response bundle between a requester and add16_seq.
// The requester drives start/op/operands; the adder returns status and result.
interface add16_seq_if #(
    parameter int W = 16
);
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         co;
    logic         ovf;

    modport master (
        output start, op, a, b,
        input  busy, done, result, co, ovf
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, co, ovf
    );
endinterface

// File: rtl/add16_seq_cla4_slice.sv
// 4-bit carry-lookahead slice; c3 is the carry into bit 3, used for overflow.
module cla4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_c1;
    logic       w_c2;

    assign w_g = x & y;
    assign w_p = x ^ y;

    assign w_c1 = w_g[0] | (w_p[0] & ci);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign c3   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign co   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

    assign s = w_p ^ {c3, w_c2, w_c1, ci};
endmodule

// File: rtl/add16_seq.sv
// Nibble-serial add/subtract: one 4-bit lookahead slice reused N_NIB times.
// Subtract is a + ~b + 1, so co=1 means no borrow.
module add16_seq
    import add16_seq_pkg::*;
#(
    parameter int N_NIB = 4
) (
    input  logic        clk,
    input  logic        reset,
    add16_seq_if.slave  bus
);
    localparam int W  = 4 * N_NIB;
    localparam int CW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_NIB - 1);

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_res;
    logic [CW-1:0] r_cnt;
    logic          r_cy;
    logic          r_co;
    logic          r_ovf;
    logic          r_busy;
    logic          r_done;

    logic [3:0]    w_x;
    logic [3:0]    w_y;
    logic [3:0]    w_s;
    logic          w_c3;
    logic          w_co;

    assign w_x = r_a[4*r_cnt +: 4];
    assign w_y = r_b[4*r_cnt +: 4];

    cla4_slice u_slice (
        .x  (w_x),
        .y  (w_y),
        .ci (r_cy),
        .s  (w_s),
        .c3 (w_c3),
        .co (w_co)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_cy    <= 1'b0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        r_cy    <= bus.op;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_co    <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res[4*r_cnt +: 4] <= w_s;
                    r_cy                <= w_co;
                    if (r_cnt == LAST) begin
                        r_co    <= w_co;
                        r_ovf   <= w_c3 ^ w_co;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_res;
    assign bus.co     = r_co;
    assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_add16_seq.sv
// Bench for add16_seq: directed vector table, random ops against an
// arithmetic model, plus ignored-start and mid-run reset sequences.
module tb_add16_seq;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    add16_seq_if #(.W(16)) bus ();

    add16_seq #(.N_NIB(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] r;
        logic        c;
        logic        v;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic op, output logic [15:0] r,
                                  output logic c, output logic v);
        int sa;
        int sb;
        int sr;
        logic [16:0] u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (op) begin
            u  = {1'b0, a} - {1'b0, b};
            c  = (a >= b);
            sr = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b};
            c  = u[16];
            sr = sa + sb;
        end
        r = u[15:0];
        v = (sr > 32767) || (sr < -32768);
    endfunction

    task automatic scramble();
        bus.a  = 16'($urandom);
        bus.b  = 16'($urandom);
        bus.op = 1'($urandom);
    endtask

    // Call one step after a clock edge with the DUT idle.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                          input logic iop, output logic [15:0] rr,
                          output logic rc, output logic rv);
        int n;
        int nb;
        bit seen;
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        bus.op    = iop;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();
        n    = 0;
        nb   = bus.busy ? 1 : 0;
        seen = 1'b0;
        rr   = '0;
        rc   = 1'b0;
        rv   = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.busy) nb++;
            if (bus.done) begin
                seen = 1'b1;
                rr   = bus.result;
                rc   = bus.co;
                rv   = bus.ovf;
            end
            scramble();
        end
        chk("done_latency", 32'(n), 32'(4));
        chk("busy_cycles", 32'(nb), 32'(5));
        @(posedge clk); #1;
        chk("done_width", 32'(bus.done), 32'(0));
        chk("busy_end", 32'(bus.busy), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("hold_result", 32'(bus.result), 32'(rr));
        chk("hold_flags", 32'({bus.co, bus.ovf}), 32'({rc, rv}));
    endtask

    initial begin
        logic [15:0] r;
        logic        c;
        logic        v;
        logic [15:0] er;
        logic        ec;
        logic        ev;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rop;
        int          ndone;

        checks = 0;
        errors = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[4] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_result", 32'(bus.result), 32'(0));
        chk("rst_flags", 32'({bus.co, bus.ovf}), 32'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].op, r, c, v);
            chk($sformatf("vec%0d_result", i), 32'(r), 32'(tbl[i].r));
            chk($sformatf("vec%0d_co", i), 32'(c), 32'(tbl[i].c));
            chk($sformatf("vec%0d_ovf", i), 32'(v), 32'(tbl[i].v));
        end

        for (int i = 0; i < 40; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rop = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            model(ra, rb, rop, er, ec, ev);
            run_op(ra, rb, rop, r, c, v);
            chk($sformatf("rnd%0d_result", i), 32'(r), 32'(er));
            chk($sformatf("rnd%0d_flags", i), 32'({c, v}), 32'({ec, ev}));
        end

        // Second start while busy must be dropped, not queued.
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.op    = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        er = '0;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) begin
                bus.start = 1'b1;
                bus.a     = 16'hFFFF;
                bus.b     = 16'hFFFF;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                er = bus.result;
            end
        end
        chk("ignore_done_cnt", 32'(ndone), 32'(1));
        chk("ignore_result", 32'(er), 32'(16'h3333));
        chk("ignore_idle", 32'(bus.busy), 32'(0));

        // Reset on the second RUN cycle aborts without a done pulse.
        bus.start = 1'b1;
        bus.a     = 16'h5678;
        bus.b     = 16'h1111;
        bus.op    = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'(0));
        chk("abort_done", 32'(bus.done), 32'(0));
        chk("abort_result", 32'(bus.result), 32'(0));
        chk("abort_flags", 32'({bus.co, bus.ovf}), 32'(0));
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'(0));
        run_op(16'hABCD, 16'h1234, 1'b1, r, c, v);
        model(16'hABCD, 16'h1234, 1'b1, er, ec, ev);
        chk("after_abort_result", 32'(r), 32'(er));
        chk("after_abort_flags", 32'({c, v}), 32'({ec, ev}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
